// File: rtl/activate_pipe.sv
// activate_pipe: multi-lane activation stage (bypass / ReLU / leaky ReLU /
// clamped ReLU) on a two-stage valid/ready pipeline with full backpressure,
// plus a saturating debug counter of output beats that hit the clamp.
module activate_pipe #(
  parameter int DATA_W     = 18,
  parameter int LANES      = 2,
  parameter int LEAK_SHIFT = 3,
  parameter int CLAMP_MAX  = 24576
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_sat,
  input  logic                    cnt_clr,
  output logic [15:0]             clamp_cnt
);

  localparam logic signed [DATA_W-1:0] CLAMP_V = DATA_W'(CLAMP_MAX);

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_RELU   = 2'd1;
  localparam logic [1:0] MODE_LEAKY  = 2'd2;
  localparam logic [1:0] MODE_CLAMP  = 2'd3;

  // Leaky slope: arithmetic shift floors toward -inf, so -1 stays -1.
  function automatic logic signed [DATA_W-1:0] leak_shift(
    input logic signed [DATA_W-1:0] x
  );
    return x >>> LEAK_SHIFT;
  endfunction

  // Upper saturation for clamp mode; only meaningful for non-negative x.
  function automatic logic signed [DATA_W-1:0] clamp_hi(
    input logic signed [DATA_W-1:0] x
  );
    return (x > CLAMP_V) ? CLAMP_V : x;
  endfunction

  function automatic logic sat_flag(input logic signed [DATA_W-1:0] x);
    return x > CLAMP_V;
  endfunction

  function automatic logic signed [DATA_W-1:0] act_lane(
    input logic signed [DATA_W-1:0] x,
    input logic [1:0]               mode
  );
    case (mode)
      MODE_BYPASS: return x;
      MODE_RELU:   return x[DATA_W-1] ? '0 : x;
      MODE_LEAKY:  return x[DATA_W-1] ? leak_shift(x) : x;
      default:     return x[DATA_W-1] ? '0 : clamp_hi(x);
    endcase
  endfunction

  logic                    vld_p1;
  logic [LANES*DATA_W-1:0] data_p1;
  logic [1:0]              mode_p1;

  logic                    vld_p2;
  logic [LANES*DATA_W-1:0] data_p2;
  logic [LANES-1:0]        sat_p2;

  logic                    adv1;
  logic                    adv2;
  logic                    out_fire;
  logic [LANES*DATA_W-1:0] act_data;
  logic [LANES-1:0]        act_sat;

  // A stage may load when it is empty or its content moves on this edge.
  assign adv2      = !vld_p2 || out_ready;
  assign adv1      = !vld_p1 || adv2;
  assign in_ready  = rst_n && adv1;
  assign out_fire  = vld_p2 && out_ready;
  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_sat   = sat_p2;

  // ---- stage 1: capture raw samples and mode on an input transfer ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (adv1) begin
      vld_p1 <= in_valid;
    end
  end

  // Stage-1 payload is don't-care while vld_p1 is low, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      data_p1 <= in_data;
      mode_p1 <= in_mode;
    end
  end

  // Per-lane activation of the stage-1 beat.
  always_comb begin
    act_data = '0;
    act_sat  = '0;
    for (int k = 0; k < LANES; k++) begin
      act_data[k*DATA_W +: DATA_W] = act_lane(data_p1[k*DATA_W +: DATA_W], mode_p1);
      act_sat[k] = (mode_p1 == MODE_CLAMP) && sat_flag(data_p1[k*DATA_W +: DATA_W]);
    end
  end

  // ---- stage 2: register activated result; holds while stalled ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      sat_p2  <= '0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= act_data;
        sat_p2  <= act_sat;
      end
    end
  end

  // Debug counter of delivered beats with any clamped lane; clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clamp_cnt <= '0;
    end else if (cnt_clr) begin
      clamp_cnt <= '0;
    end else if (out_fire && (|sat_p2) && (clamp_cnt != 16'hFFFF)) begin
      clamp_cnt <= clamp_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_activate_pipe.sv
// Testbench for activate_pipe: directed vectors plus randomized mixed-mode
// traffic against an integer-arithmetic reference model and scoreboard.
module tb_activate_pipe;

  localparam int DW    = 18;
  localparam int LN    = 2;
  localparam int W     = DW * LN;
  localparam int SHIFT = 3;
  localparam int CMAX  = 24576;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [1:0]    in_mode = 2'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [LN-1:0] out_sat;
  logic          cnt_clr = 1'b0;
  logic [15:0]   clamp_cnt;

  activate_pipe #(
    .DATA_W(DW), .LANES(LN), .LEAK_SHIFT(SHIFT), .CLAMP_MAX(CMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .cnt_clr(cnt_clr), .clamp_cnt(clamp_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [LN-1:0] s;
    logic [31:0]   cyc;
  } beat_t;

  beat_t         exp_q[$];
  logic [W-1:0]  got_d[$];
  logic [LN-1:0] got_s[$];

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            model_cnt = 0;
  logic          hold_prev = 1'b0;
  logic [W-1:0]  prev_d = '0;
  logic [LN-1:0] prev_s = '0;
  logic          last_fire = 1'b0;
  logic          lat_chk = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int l0, input int l1);
    logic [W-1:0] r;
    int a, b;
    a = l0;
    b = l1;
    r[0 +: DW]  = a[DW-1:0];
    r[DW +: DW] = b[DW-1:0];
    return r;
  endfunction

  // Reference: activation defined on plain integers, floor division for leak.
  function automatic void model(input logic [W-1:0] d, input logic [1:0] m,
                                output logic [W-1:0] y, output logic [LN-1:0] s);
    int x, r, q, div;
    div = 1 << SHIFT;
    y = '0;
    s = '0;
    for (int k = 0; k < LN; k++) begin
      x = int'($signed(d[k*DW +: DW]));
      case (m)
        2'd0: r = x;
        2'd1: r = (x < 0) ? 0 : x;
        2'd2: begin
          if (x < 0) begin
            q = x / div;
            if (q * div != x) q = q - 1;
            r = q;
          end else begin
            r = x;
          end
        end
        default: r = (x < 0) ? 0 : ((x > CMAX) ? CMAX : x);
      endcase
      s[k] = (m == 2'd3) && (x > CMAX);
      y[k*DW +: DW] = r[DW-1:0];
    end
  endfunction

  function automatic logic [DW-1:0] rand_sample();
    int v;
    case ($urandom_range(0, 7))
      0: v = -131072;
      1: v = 131071;
      2: v = CMAX;
      3: v = CMAX + 1;
      4: v = -1;
      5: v = 0;
      default: v = int'($urandom_range(0, 262143)) - 131072;
    endcase
    return v[DW-1:0];
  endfunction

  // One clock cycle: drive at negedge, evaluate handshakes 1 ns later.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic [1:0] m,
                      input logic ordy, input logic clr);
    beat_t         e;
    logic [W-1:0]  yd;
    logic [LN-1:0] ys;
    @(negedge clk);
    if (hold_prev) begin
      chk("hold_data", out_data, prev_d);
      chk("hold_sat", out_sat, prev_s);
    end
    in_valid  = iv;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    chk("in_ready", in_ready, (exp_q.size() == 2 && !ordy) ? 1'b0 : 1'b1);
    last_fire = out_valid && out_ready;
    if (last_fire) begin
      if (exp_q.size() == 0) begin
        chk("out_valid_empty", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_sat", out_sat, e.s);
        if (lat_chk) chk("latency", cyc - int'(e.cyc), 2);
        got_d.push_back(out_data);
        got_s.push_back(out_sat);
      end
    end
    if (clr) model_cnt = 0;
    else if (last_fire && (|out_sat) && model_cnt < 65535) model_cnt++;
    if (iv && in_ready) begin
      model(d, m, yd, ys);
      e.d = yd;
      e.s = ys;
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    hold_prev = out_valid && !out_ready;
    prev_d = out_data;
    prev_s = out_sat;
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      step(1'b0, '0, 2'd0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("in_ready_in_rst", in_ready, 0);
    repeat (n) @(negedge clk);
    chk("in_ready_in_rst_late", in_ready, 0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
    model_cnt = 0;
    hold_prev = 1'b0;
    #1;
  endtask

  initial begin
    // Test 1: reset and idle
    do_reset(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_clamp_cnt", clamp_cnt, 0);
    chk("post_rst_in_ready", in_ready, 1);

    lat_chk = 1'b1;
    // Test 2: ReLU
    got_d.delete(); got_s.delete();
    step(1'b1, pack(0, 12345), 2'd1, 1'b1, 1'b0);
    step(1'b1, pack(-1, -32768), 2'd1, 1'b1, 1'b0);
    step(1'b1, pack(32767, 1), 2'd1, 1'b1, 1'b0);
    drain();
    chk("relu_n", got_d.size(), 3);
    if (got_d.size() == 3) begin
      chk("relu_0", got_d[0], pack(0, 12345));
      chk("relu_1", got_d[1], pack(0, 0));
      chk("relu_2", got_d[2], pack(32767, 1));
    end

    // Test 3: leaky
    got_d.delete(); got_s.delete();
    step(1'b1, pack(-8, -1), 2'd2, 1'b1, 1'b0);
    step(1'b1, pack(-9, 100), 2'd2, 1'b1, 1'b0);
    step(1'b1, pack(-131072, 5), 2'd2, 1'b1, 1'b0);
    drain();
    chk("leaky_n", got_d.size(), 3);
    if (got_d.size() == 3) begin
      chk("leaky_0", got_d[0], pack(-1, -1));
      chk("leaky_1", got_d[1], pack(-2, 100));
      chk("leaky_2", got_d[2], pack(-16384, 5));
    end

    // Test 4: clamp, counter, clear coinciding with a saturating transfer
    got_d.delete(); got_s.delete();
    step(1'b1, pack(24576, 24577), 2'd3, 1'b1, 1'b0);
    step(1'b1, pack(-5, 30000), 2'd3, 1'b1, 1'b0);
    drain();
    chk("clamp_n", got_d.size(), 2);
    if (got_d.size() == 2) begin
      chk("clamp_d0", got_d[0], pack(24576, 24576));
      chk("clamp_s0", got_s[0], 2'b10);
      chk("clamp_d1", got_d[1], pack(0, 24576));
      chk("clamp_s1", got_s[1], 2'b10);
    end
    chk("clamp_cnt_2", clamp_cnt, 2);
    step(1'b1, pack(0, 30000), 2'd3, 1'b1, 1'b0);
    step(1'b0, '0, 2'd0, 1'b1, 1'b0);
    step(1'b0, '0, 2'd0, 1'b1, 1'b1);
    chk("clr_on_fire", last_fire, 1);
    @(posedge clk);
    #1;
    chk("clamp_cnt_clr", clamp_cnt, 0);
    step(1'b0, '0, 2'd0, 1'b1, 1'b0);

    // Reset with two beats in flight
    lat_chk = 1'b0;
    step(1'b1, pack(1, 2), 2'd0, 1'b0, 1'b0);
    step(1'b1, pack(3, 4), 2'd0, 1'b0, 1'b0);
    step(1'b1, pack(5, 6), 2'd0, 1'b0, 1'b0);
    do_reset(1);
    chk("inflight_dropped", out_valid, 0);
    repeat (4) step(1'b0, '0, 2'd0, 1'b1, 1'b0);

    // Test 5: randomized mixed-mode traffic with backpressure
    for (int i = 0; i < 1500; i++) begin
      logic ordy;
      ordy = (i < 750) ? 1'($urandom_range(0, 1)) : ((i % 3) == 0);
      step(($urandom_range(0, 7) != 0), {rand_sample(), rand_sample()},
           2'(i % 4), ordy, ($urandom_range(0, 199) == 0));
    end
    drain();
    chk("rand_cnt", clamp_cnt, model_cnt);

    // Test 6: counter saturation
    step(1'b0, '0, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 65537; i++) step(1'b1, pack(30000, -3), 2'd3, 1'b1, 1'b0);
    drain();
    chk("cnt_sat_model", clamp_cnt, model_cnt);
    chk("cnt_sat", clamp_cnt, 16'hFFFF);
    step(1'b1, pack(30000, 30000), 2'd3, 1'b1, 1'b0);
    drain();
    chk("cnt_sat_hold", clamp_cnt, 16'hFFFF);
    step(1'b0, '0, 2'd0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("cnt_clr_after_sat", clamp_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
